// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit and its history table.
// Contents:
//   OP_*      3-bit branch-type encoding carried with each branch.
//   CTR_*     2-bit saturating predictor counter states.
//   ctr_step  one saturating training step of a predictor counter.
package branch_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BGEZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BLEZ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Move one step toward taken or not-taken; sticks at both ends.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// DEPTH-entry table of 2-bit saturating predictor counters.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   rd_idx      fetch lookup index (asynchronous read)
//   rd_pred     prediction = MSB of the counter at rd_idx
//   upd_en      apply one training step this edge
//   upd_idx     entry to train
//   upd_taken   direction of the training step
// Reads see the pre-edge value; there is no write-to-read bypass.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_pred = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch condition evaluation, one-cycle registered resolution, predictor
// training and saturating statistics.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid, stall   branch presented / downstream stall (freezes unit)
//   op, rs, rt        branch type and two's-complement operands
//   pc, pred_taken    branch PC (table index) and the prediction it carried
//   fetch_pc          fetch lookup PC; fetch_pred is the combinational answer
//   out_valid, taken, mispredict   registered outcome of the accepted branch
//   branch_count, mispredict_count saturating statistics
// Handshake: a branch is taken in when in_valid=1, stall=0 and op is one of
// the six real branch types. There is no ready: stall is the only
// backpressure, and while it is high every register (outputs, table,
// counts) holds and the presented branch is not consumed.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [PC_W-1:0]  pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             fetch_pred,
  output logic             out_valid,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic cond;
  logic op_ok;
  logic accept;
  logic mis;

  // Sign and zero tests replace a subtractor for the compare-with-zero ops.
  logic rs_neg;
  logic rs_zero;
  assign rs_neg  = rs[WIDTH-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    cond  = 1'b0;
    op_ok = 1'b1;
    case (op)
      OP_BEQ:  cond = (rs == rt);
      OP_BNE:  cond = (rs != rt);
      OP_BGTZ: cond = !rs_neg && !rs_zero;
      OP_BGEZ: cond = !rs_neg;
      OP_BLTZ: cond = rs_neg;
      OP_BLEZ: cond = rs_neg || rs_zero;
      default: op_ok = 1'b0;   // OP_NONE, OP_RSVD
    endcase
  end

  assign accept = in_valid && !stall && op_ok;
  assign mis    = cond != pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      taken            <= 1'b0;
      mispredict       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (!stall) begin
      out_valid  <= accept;
      taken      <= accept && cond;
      mispredict <= accept && mis;
      if (accept && branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_W'(1);
      if (accept && mis && mispredict_count != CNT_MAX)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

  branch_history_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_pred   (fetch_pred),
    .upd_en    (accept),
    .upd_idx   (pc[IDX_W+1:2]),
    .upd_taken (cond)
  );

  // Only the index bits of the PCs are meaningful to this unit.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc, fetch_pc};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [31:0] CNT_MAX = 32'd15;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             stall;
  logic [2:0]       op;
  logic [31:0]      rs;
  logic [31:0]      rt;
  logic [31:0]      pc;
  logic             pred_taken;
  logic [31:0]      fetch_pc;
  logic             fetch_pred;
  logic             out_valid;
  logic             taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {valid, taken, mispredict} expected after the next edge.
  logic [2:0]  exp_q[$];
  logic [31:0] exp_bc;
  logic [31:0] exp_mc;

  branch_resolve_unit #(
    .WIDTH (32),
    .DEPTH (64),
    .PC_W  (32),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .stall            (stall),
    .op               (op),
    .rs               (rs),
    .rt               (rt),
    .pc               (pc),
    .pred_taken       (pred_taken),
    .fetch_pc         (fetch_pc),
    .fetch_pred       (fetch_pred),
    .out_valid        (out_valid),
    .taken            (taken),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_bc"}, 32'(branch_count), exp_bc);
    check({tag, "_mc"}, 32'(mispredict_count), exp_mc);
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'(e[2]));
      check({tag, "_taken"}, 32'(taken), 32'(e[1]));
      check({tag, "_mis"},   32'(mispredict), 32'(e[0]));
    end
  endtask

  // Present one branch for one unstalled edge; t_exp is the hand-computed outcome.
  task automatic send(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic pr,
                      input logic v_exp, input logic t_exp);
    logic m_exp;
    m_exp = v_exp && (t_exp != pr);
    in_valid = 1'b1; stall = 1'b0;
    op = o; rs = a; rt = b; pc = p; pred_taken = pr;
    exp_q.push_back({v_exp, v_exp && t_exp, m_exp});
    if (v_exp && exp_bc != CNT_MAX) exp_bc++;
    if (m_exp && exp_mc != CNT_MAX) exp_mc++;
    step();
    in_valid = 1'b0;
    check_outputs(tag);
    check_counts(tag);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] fpc, input logic exp);
    fetch_pc = fpc;
    #1;
    check(tag, 32'(fetch_pred), 32'(exp));
  endtask

  logic exp_pred_seq [4];

  initial begin
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; op = OP_NONE;
    rs = '0; rt = '0; pc = '0; pred_taken = 1'b0; fetch_pc = '0;
    exp_bc = 0; exp_mc = 0;
    exp_pred_seq[0] = 1'b0; exp_pred_seq[1] = 1'b1;
    exp_pred_seq[2] = 1'b1; exp_pred_seq[3] = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_mis", 32'(mispredict), 32'd0);
    check_counts("rst");
    check_fetch("rst_fetch0", 32'h0, 1'b0);
    check_fetch("rst_fetch_fc", 32'hfc, 1'b0);

    // Signed compares
    send("bgtz_min", OP_BGTZ, 32'h8000_0000, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0);
    send("bltz_min", OP_BLTZ, 32'h8000_0000, 32'h0, 32'h100, 1'b0, 1'b1, 1'b1);
    send("blez_zero", OP_BLEZ, 32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b1);
    send("bgez_zero", OP_BGEZ, 32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b1);
    send("bgtz_max", OP_BGTZ, 32'h7fff_ffff, 32'h0, 32'h100, 1'b1, 1'b1, 1'b1);
    send("bgtz_zero", OP_BGTZ, 32'h0, 32'h0, 32'h100, 1'b1, 1'b1, 1'b0);
    send("bltz_zero", OP_BLTZ, 32'h0, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0);
    send("blez_pos", OP_BLEZ, 32'h1, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0);
    send("bgez_neg1", OP_BGEZ, 32'hffff_ffff, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0);

    // Equality and first-count values
    do_reset();
    send("beq_eq", OP_BEQ, 32'd5, 32'd5, 32'h200, 1'b0, 1'b1, 1'b1);
    send("bne_eq", OP_BNE, 32'd5, 32'd5, 32'h200, 1'b0, 1'b1, 1'b0);
    send("beq_msb", OP_BEQ, 32'd5, 32'h8000_0005, 32'h200, 1'b1, 1'b1, 1'b0);
    send("bne_msb", OP_BNE, 32'd5, 32'h8000_0005, 32'h200, 1'b1, 1'b1, 1'b1);

    // Training at pc 0x40 (idx 16): 1->2->3->3, lookup before each edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check_fetch($sformatf("train_pre%0d", i), 32'h40, exp_pred_seq[i]);
      send($sformatf("train%0d", i), OP_BEQ, 32'd1, 32'd1, 32'h40, 1'b1, 1'b1, 1'b1);
    end
    check_fetch("train_post", 32'h40, 1'b1);
    check_fetch("train_alias", 32'h140, 1'b1);
    check_fetch("train_neighbor", 32'h44, 1'b0);
    // Walk down 3->2->1->0, hold at 0, then one up must land on 1 (pred 0)
    send("dec0", OP_BNE, 32'd1, 32'd1, 32'h40, 1'b1, 1'b1, 1'b0);
    check_fetch("dec0_pred", 32'h40, 1'b1);
    send("dec1", OP_BNE, 32'd1, 32'd1, 32'h40, 1'b1, 1'b1, 1'b0);
    check_fetch("dec1_pred", 32'h40, 1'b0);
    send("dec2", OP_BNE, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 1'b0);
    send("dec3", OP_BNE, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 1'b0);
    send("inc_from0", OP_BEQ, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 1'b1);
    check_fetch("inc_from0_pred", 32'h40, 1'b0);
    send("inc_to2", OP_BEQ, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1, 1'b1);
    check_fetch("inc_to2_pred", 32'h40, 1'b1);

    // Stall: last result (taken, mispredicted) must hold for 3 cycles
    in_valid = 1'b1; stall = 1'b1;
    op = OP_BEQ; rs = 32'd9; rt = 32'd9; pc = 32'h80; pred_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_taken", i), 32'(taken), 32'd1);
      check($sformatf("stall%0d_mis", i), 32'(mispredict), 32'd1);
      check_counts($sformatf("stall%0d", i));
      check_fetch($sformatf("stall%0d_fetch", i), 32'h80, 1'b0);
    end
    send("stall_release", OP_BEQ, 32'd9, 32'd9, 32'h80, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(3'b000);
    step();
    check_outputs("after_release");
    check_counts("after_release");
    check_fetch("after_release_fetch", 32'h80, 1'b1);

    // Non-branch ops are ignored entirely
    send("op_none", OP_NONE, 32'd3, 32'd3, 32'hc0, 1'b0, 1'b0, 1'b0);
    check_fetch("op_none_fetch", 32'hc0, 1'b0);
    send("op_rsvd", OP_RSVD, 32'd3, 32'd3, 32'hc0, 1'b0, 1'b0, 1'b0);
    check_fetch("op_rsvd_fetch", 32'hc0, 1'b0);

    // Reset wins over a simultaneous accepted branch
    rst = 1'b1; in_valid = 1'b1; stall = 1'b0;
    op = OP_BEQ; rs = 32'd2; rt = 32'd2; pc = 32'h40; pred_taken = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    exp_bc = 0; exp_mc = 0;
    check("rstacc_valid", 32'(out_valid), 32'd0);
    check("rstacc_taken", 32'(taken), 32'd0);
    check("rstacc_mis", 32'(mispredict), 32'd0);
    check_counts("rstacc");
    check_fetch("rstacc_fetch40", 32'h40, 1'b0);
    check_fetch("rstacc_fetch80", 32'h80, 1'b0);

    // Statistics saturate at 15 with CNT_W=4
    for (int i = 0; i < 20; i++)
      send($sformatf("sat%0d", i), OP_BLTZ, 32'hffff_fff0, 32'h0, 32'h300, 1'b0, 1'b1, 1'b1);
    check("sat_bc_final", 32'(branch_count), 32'd15);
    check("sat_mc_final", 32'(mispredict_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
